// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the UART receive controller.
//   rx_state_e : controller state encoding (IDLE / START_CHK / RECEIVE)
//   BASE_BITS  : frame bits after the start bit with EIGHT = PEN = 0
//                (7 data bits + 1 stop bit)
//   MIN_K      : smallest usable clocks-per-bit value; smaller requests are
//                raised to this so the half-bit target never reaches zero
// ---------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        START_CHK = 2'b01,
        RECEIVE   = 2'b10
    } rx_state_e;

    localparam int BASE_BITS = 8;
    localparam int MIN_K     = 2;

endpackage

// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer
// Bit-time counter and target compare for the receive controller.
// The counter runs while a frame is in progress. It raises BTU on the last
// cycle of each half bit (start-bit check) or full bit (data bits).
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   DOIT   in   frame in progress; counter is held at zero otherwise
//   START  in   start-bit check phase; selects the half-bit target
//   K_l    in   latched, clamped clocks-per-bit (always >= 2)
//   BTU    out  one-cycle bit-time-up strobe
// ---------------------------------------------------------------------------
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DOIT,
    input  logic              START,
    input  logic [BAUD_W-1:0] K_l,
    output logic              BTU
);

    logic [BAUD_W-1:0] count_q;
    logic [BAUD_W-1:0] count_d;
    logic [BAUD_W-1:0] target;

    // K_l is never below 2, so the half-bit target is at least 1. The
    // subtraction below therefore cannot wrap.
    always_comb begin
        target  = START ? (K_l >> 1) : K_l;
        BTU     = DOIT && (count_q == (target - BAUD_W'(1)));
        count_d = count_q + BAUD_W'(1);
        if (!DOIT || BTU) begin
            count_d = '0;
        end
    end

    // START_CHK->RECEIVE and RECEIVE->IDLE both happen on a BTU, so the clear
    // on BTU covers them. A false start leaves a stale count for one IDLE
    // cycle. That count cannot strobe because BTU is gated by DOIT, and it is
    // zeroed before START_CHK can be re-entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// rx_ctrl_fsm
// Receive-engine controller. It detects a start edge and checks the start bit
// at half a bit time. It then issues one BTU per bit (mid-bit) and a DONE
// pulse on the last BTU of the frame.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   RX      in   synchronized serial input, idle high
//   BAUD_K  in   clocks per bit (values below 2 behave as 2)
//   EIGHT   in   1 = 8 data bits, 0 = 7 data bits
//   PEN     in   parity enable
//   START   out  start-bit check in progress
//   DOIT    out  frame in progress
//   BTU     out  one-cycle bit-time-up strobe
//   DONE    out  one-cycle end-of-frame strobe
// ---------------------------------------------------------------------------
module rx_ctrl_fsm
    import rx_pkg::*;
#(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic [BAUD_W-1:0] BAUD_K,
    input  logic              EIGHT,
    input  logic              PEN,
    output logic              START,
    output logic              DOIT,
    output logic              BTU,
    output logic              DONE
);

    rx_state_e         state_q;
    rx_state_e         state_d;
    logic [BAUD_W-1:0] kLat_q;
    logic [BAUD_W-1:0] kClamped;
    logic              eightLat_q;
    logic              penLat_q;
    logic [3:0]        bitCnt_q;
    logic [3:0]        lastBit;
    logic              btuRaw;
    logic              falseStart;
    logic              cfgLoad;

    // Moore outputs taken straight from the state register.
    assign START = (state_q == START_CHK);
    assign DOIT  = (state_q != IDLE);

    // Configuration is sampled on the same edge that enters START_CHK.
    assign cfgLoad  = (state_q == IDLE) && !RX;
    assign kClamped = (BAUD_K < BAUD_W'(MIN_K)) ? BAUD_W'(MIN_K) : BAUD_K;

    // Index of the final bit after the start bit: NUM-1 = 7 + EIGHT + PEN.
    assign lastBit = 4'(BASE_BITS - 1) + {3'b000, eightLat_q} + {3'b000, penLat_q};

    rx_bit_timer #(
        .BAUD_W (BAUD_W)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .DOIT  (DOIT),
        .START (START),
        .K_l   (kLat_q),
        .BTU   (btuRaw)
    );

    // A high line during the start check aborts the frame. This takes
    // priority over a coincident half-bit strobe, which must not reach the
    // datapath.
    assign falseStart = (state_q == START_CHK) && RX;
    assign BTU        = btuRaw && !falseStart;
    assign DONE       = BTU && (state_q == RECEIVE) && (bitCnt_q == lastBit);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!RX) begin
                    state_d = START_CHK;
                end
            end
            START_CHK: begin
                if (RX) begin
                    state_d = IDLE;
                end else if (btuRaw) begin
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                if (DONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame configuration latch. Mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            kLat_q     <= '0;
            eightLat_q <= 1'b0;
            penLat_q   <= 1'b0;
        end else if (cfgLoad) begin
            kLat_q     <= kClamped;
            eightLat_q <= EIGHT;
            penLat_q   <= PEN;
        end
    end

    // Bit counter. It is held at zero outside RECEIVE, so it always enters
    // RECEIVE cleared. It counts the RECEIVE strobes of the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt_q <= '0;
        end else if (state_q != RECEIVE) begin
            bitCnt_q <= '0;
        end else if (BTU) begin
            bitCnt_q <= bitCnt_q + 4'd1;
        end
    end

endmodule
